pwm_motor_driver: RTL and testbench

//  Parametrised N-channel PWM H-bridge drive. Each channel gets a duty command and a direction.

---
 rtl/pwm_motor_pkg.sv | 31 +++
 rtl/pwm_motor_channel.sv | 172 +++++++++++++++++
 rtl/pwm_motor_driver.sv | 93 +++++++++
 tb/tb_pwm_motor_driver.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_motor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_motor_pkg
//  Purpose  : Shared types and helpers for the PWM H-bridge motor driver:
//             channel state encoding, percent width and duty clamp.
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_motor_pkg;

  // Duty values are whole percent, 0..100 fits in 7 bits.
  localparam int unsigned PCT_W = 7;

  // Per-channel reversal sequencer states.
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_RAMP_DOWN = 2'd1,
    ST_DEAD      = 2'd2
  } chState_t;

  // Saturate a raw command at 100 %, then clip it to the stall limit.
  function automatic logic [PCT_W-1:0] clampPct(input logic [PCT_W-1:0] pct,
                                                input int unsigned      maxPct);
    logic [PCT_W-1:0] lim;
    logic [PCT_W-1:0] sat;
    lim = (maxPct > 100) ? PCT_W'(100) : PCT_W'(maxPct);
    sat = (pct > PCT_W'(100)) ? PCT_W'(100) : pct;
    return (sat > lim) ? lim : sat;
  endfunction

endpackage : pwm_motor_pkg
`default_nettype wire

// File: rtl/pwm_motor_channel.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_motor_channel
//  Purpose  : One H-bridge channel: duty clamp, slew-limited ramp, on-time
//             computation, safe-reversal sequencer and registered bridge pins.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_motor_channel
  import pwm_motor_pkg::*;
#(
  parameter int unsigned PERIOD       = 625_000,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned MAX_PCT      = 80,
  parameter int unsigned RAMP_STEP    = 10,
  parameter int unsigned DEAD_PERIODS = 2,
  parameter bit          INVERT       = 1'b0
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             tick,
  input  logic [CNT_W-1:0] count,
  input  logic             stopped,
  input  logic [PCT_W-1:0] dutyPct,
  input  logic             dirRev,
  output logic             hbEn,
  output logic             hbInA,
  output logic             hbInB,
  output logic             busy
);

  // Counter must hold DEAD_PERIODS and never collapse to zero width.
  localparam int unsigned     DEAD_W   = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);
  localparam logic [PCT_W-1:0] STEP    = PCT_W'(RAMP_STEP);
  localparam int unsigned     PROD_W   = CNT_W + PCT_W;
  localparam logic [PROD_W-1:0] PERIOD_X = PROD_W'(PERIOD);
  localparam logic [PROD_W-1:0] HUNDRED  = PROD_W'(100);

  chState_t          r_state;
  chState_t          w_stateNext;
  logic [DEAD_W-1:0] r_deadCnt;
  logic [DEAD_W-1:0] w_deadCntNext;
  logic              r_curDir;
  logic              w_curDirNext;
  logic [PCT_W-1:0]  r_curPct;
  logic [PCT_W-1:0]  w_target;
  logic [PCT_W-1:0]  w_goal;
  logic [PCT_W-1:0]  w_nextPct;
  logic [PCT_W-1:0]  w_delta;
  logic [CNT_W-1:0]  r_onCnt;
  logic [CNT_W-1:0]  w_onCntNext;
  logic [PROD_W-1:0] w_prod;
  logic              r_hbEn;
  logic              r_inA;
  logic              r_inB;
  logic              w_drive;
  logic              w_dirA;

  assign w_target = clampPct(dutyPct, MAX_PCT);

  // Sequencer state register: state, dead-time counter and applied direction.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state   <= ST_RUN;
      r_deadCnt <= '0;
      r_curDir  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_deadCnt <= w_deadCntNext;
      r_curDir  <= w_curDirNext;
    end
  end

  // Next-state logic and ramp goal; the stop latch overrides everything.
  always_comb begin
    w_stateNext   = r_state;
    w_deadCntNext = r_deadCnt;
    w_curDirNext  = r_curDir;
    w_goal        = w_target;
    case (r_state)
      ST_RUN: begin
        w_goal = w_target;
        if (dirRev != r_curDir) begin
          w_stateNext = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        // A request that flips back here is ignored; the swap samples dirRev at DEAD exit.
        w_goal = '0;
        if (tick && (r_curPct == '0)) begin
          w_stateNext   = ST_DEAD;
          w_deadCntNext = DEAD_W'(DEAD_PERIODS);
        end
      end
      ST_DEAD: begin
        w_goal = '0;
        if (tick) begin
          // Count of 0 or 1 ends the dead time at this boundary.
          if (r_deadCnt <= DEAD_W'(1)) begin
            w_stateNext   = ST_RUN;
            w_deadCntNext = '0;
            w_curDirNext  = dirRev;
          end else begin
            w_deadCntNext = r_deadCnt - DEAD_W'(1);
          end
        end
      end
      default: begin
        w_stateNext   = ST_RUN;
        w_deadCntNext = '0;
        w_goal        = '0;
      end
    endcase
    if (stopped) begin
      w_stateNext   = ST_RUN;
      w_deadCntNext = '0;
      w_goal        = '0;
    end
  end

  // Move toward the goal by at most one step without overshooting it.
  always_comb begin
    w_nextPct = r_curPct;
    w_delta   = '0;
    if (r_curPct < w_goal) begin
      w_delta   = w_goal - r_curPct;
      w_nextPct = r_curPct + ((w_delta > STEP) ? STEP : w_delta);
    end else if (r_curPct > w_goal) begin
      w_delta   = r_curPct - w_goal;
      w_nextPct = r_curPct - ((w_delta > STEP) ? STEP : w_delta);
    end
  end

  assign w_prod      = PERIOD_X * PROD_W'(w_nextPct);
  assign w_onCntNext = CNT_W'(w_prod / HUNDRED);

  // Duty and on-time update only at the period boundary, so a period never changes mid-way.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_curPct <= '0;
      r_onCnt  <= '0;
    end else if (stopped) begin
      r_curPct <= '0;
      r_onCnt  <= '0;
    end else if (tick) begin
      r_curPct <= w_nextPct;
      r_onCnt  <= w_onCntNext;
    end
  end

  assign w_drive = !stopped && (r_state != ST_DEAD);
  assign w_dirA  = r_curDir ^ INVERT;

  // Registered bridge pins; onCnt of 0 keeps enable low for the whole period.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_hbEn <= 1'b0;
      r_inA  <= 1'b0;
      r_inB  <= 1'b0;
    end else begin
      r_hbEn <= w_drive && (count < r_onCnt);
      r_inA  <= w_drive && w_dirA;
      r_inB  <= w_drive && !w_dirA;
    end
  end

  assign hbEn  = r_hbEn;
  assign hbInA = r_inA;
  assign hbInB = r_inB;
  assign busy  = (r_state != ST_RUN);

endmodule : pwm_motor_channel
`default_nettype wire

// File: rtl/pwm_motor_driver.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_motor_driver
//  Purpose  : N-channel PWM H-bridge driver with shared period counter,
//             latched collision stop and per-channel ramp/reversal logic.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_motor_driver
  import pwm_motor_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PWM_HZ       = 80,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned MAX_PCT      = 80,
  parameter int unsigned RAMP_STEP    = 10,
  parameter int unsigned DEAD_PERIODS = 2,
  parameter int unsigned INVERT_MASK  = 'b10
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic [PCT_W*NUM_CH-1:0] dutyPct,
  input  logic [NUM_CH-1:0]       dirRev,
  input  logic                    collision,
  input  logic                    resume,
  output logic [NUM_CH-1:0]       hbEn,
  output logic [NUM_CH-1:0]       hbInA,
  output logic [NUM_CH-1:0]       hbInB,
  output logic                    stopped,
  output logic [NUM_CH-1:0]       busy
);

  localparam int unsigned      PERIOD = CLK_HZ / PWM_HZ;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_tick;
  logic             r_stopped;

  assign w_tick = (r_count == LAST);

  // Shared period counter, wrapping at PERIOD-1.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Collision stop latch; collision wins over a coincident resume.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_stopped <= 1'b0;
    end else if (collision) begin
      r_stopped <= 1'b1;
    end else if (resume) begin
      r_stopped <= 1'b0;
    end
  end

  assign stopped = r_stopped;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      pwm_motor_channel #(
        .PERIOD       (PERIOD),
        .CNT_W        (CNT_W),
        .MAX_PCT      (MAX_PCT),
        .RAMP_STEP    (RAMP_STEP),
        .DEAD_PERIODS (DEAD_PERIODS),
        .INVERT       (((INVERT_MASK >> i) & 1) != 0)
      ) u_ch (
        .clock   (clock),
        .resetN  (resetN),
        .tick    (w_tick),
        .count   (r_count),
        .stopped (r_stopped),
        .dutyPct (dutyPct[PCT_W*i +: PCT_W]),
        .dirRev  (dirRev[i]),
        .hbEn    (hbEn[i]),
        .hbInA   (hbInA[i]),
        .hbInB   (hbInB[i]),
        .busy    (busy[i])
      );
    end
  endgenerate

endmodule : pwm_motor_driver
`default_nettype wire

// File: tb/tb_pwm_motor_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_motor_driver
//  Purpose  : Scoreboard bench: stimulus queues expected pulse widths and
//             level expectations, a negedge monitor compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_motor_driver;

  localparam int NUM_CH = 2;

  logic              clock = 1'b0;
  logic              resetN = 1'b0;
  logic [7*NUM_CH-1:0] dutyPct = '0;
  logic [NUM_CH-1:0] dirRev = '0;
  logic              collision = 1'b0;
  logic              resume = 1'b0;
  logic [NUM_CH-1:0] hbEn;
  logic [NUM_CH-1:0] hbInA;
  logic [NUM_CH-1:0] hbInB;
  logic              stopped;
  logic [NUM_CH-1:0] busy;

  always #5 clock = ~clock;

  pwm_motor_driver #(
    .NUM_CH       (NUM_CH),
    .CLK_HZ       (1000),
    .PWM_HZ       (10),
    .CNT_W        (20),
    .MAX_PCT      (80),
    .RAMP_STEP    (10),
    .DEAD_PERIODS (2),
    .INVERT_MASK  ('b10)
  ) dut (
    .clock     (clock),
    .resetN    (resetN),
    .dutyPct   (dutyPct),
    .dirRev    (dirRev),
    .collision (collision),
    .resume    (resume),
    .hbEn      (hbEn),
    .hbInA     (hbInA),
    .hbInB     (hbInB),
    .stopped   (stopped),
    .busy      (busy)
  );

  typedef struct {
    string name;
    int    act;
    int    exp;
  } lvl_t;

  lvl_t lvlQ[$];
  int   expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   w0 = 0;
  int   w1 = 0;
  lvl_t ent;
  int   e;

  // Monitor: resolves queued level checks and compares each finished ch0 pulse.
  always @(negedge clock) begin
    while (lvlQ.size() > 0) begin
      ent = lvlQ.pop_front();
      checks++;
      if (ent.act != ent.exp) begin
        failures++;
        $display("FAIL %s actual=%0d expected=%0d", ent.name, ent.act, ent.exp);
      end
    end
    if (!resetN) begin
      w0 = 0;
      w1 = 0;
    end else begin
      if (hbEn[0]) begin
        w0++;
      end else if (w0 > 0) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL pulse_ch0 actual=%0d expected=none", w0);
        end else begin
          e = expQ.pop_front();
          if (w0 != e) begin
            failures++;
            $display("FAIL pulse_ch0 actual=%0d expected=%0d", w0, e);
          end
        end
        w0 = 0;
      end
      if (hbEn[1]) begin
        w1++;
      end else if (w1 > 0) begin
        checks++;
        failures++;
        $display("FAIL pulse_ch1 actual=%0d expected=none", w1);
        w1 = 0;
      end
    end
  end

  task automatic lv(input string n, input int a, input int x);
    lvl_t t;
    t.name = n;
    t.act  = a;
    t.exp  = x;
    lvlQ.push_back(t);
  endtask

  task automatic pushRamp(input int a, input int b, input int s);
    for (int v = a; (s > 0) ? (v <= b) : (v >= b); v += s) expQ.push_back(v);
  endtask

  task automatic drain(input string n);
    int k = 0;
    while (expQ.size() > 0 && k < 4000) begin
      @(negedge clock);
      k++;
    end
    lv({"drain_", n}, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int k;
    int n;
    int hi;

    // Reset state
    waitNeg(3);
    lv("rst_hbEn", int'(hbEn), 0);
    lv("rst_inA", int'(hbInA), 0);
    lv("rst_inB", int'(hbInB), 0);
    lv("rst_stopped", int'(stopped), 0);
    lv("rst_busy", int'(busy), 0);
    resetN = 1'b1;
    waitNeg(3);
    lv("fwd_ch0_A", int'(hbInA[0]), 0);
    lv("fwd_ch0_B", int'(hbInB[0]), 1);
    lv("fwd_ch1_A_inv", int'(hbInA[1]), 1);
    lv("fwd_ch1_B_inv", int'(hbInB[1]), 0);

    // Test 1: ramp 0 -> 60
    dutyPct[6:0] = 7'd60;
    pushRamp(10, 60, 10);
    expQ.push_back(60);
    expQ.push_back(60);
    drain("ramp60");

    // Test 2: over-range clamps to 80, then ramp down to 0
    dutyPct[6:0] = 7'd95;
    pushRamp(70, 80, 10);
    expQ.push_back(80);
    expQ.push_back(80);
    drain("clamp80");
    dutyPct[6:0] = 7'd0;
    pushRamp(70, 10, -10);
    drain("ramp0");
    hi = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (hbEn[0]) hi++;
    end
    lv("flat_low_hbEn", hi, 0);

    // Test 3: reversal from 40 forward
    dutyPct[6:0] = 7'd40;
    pushRamp(10, 40, 10);
    expQ.push_back(40);
    drain("ramp40");
    dirRev[0] = 1'b1;
    pushRamp(30, 10, -10);
    pushRamp(10, 40, 10);
    expQ.push_back(40);
    waitNeg(2);
    lv("rev_busy", int'(busy[0]), 1);
    lv("rev_rampdn_A", int'(hbInA[0]), 0);
    lv("rev_rampdn_B", int'(hbInB[0]), 1);
    k = 0;
    while ((hbInA[0] || hbInB[0]) && k < 700) begin
      @(negedge clock);
      k++;
    end
    lv("dead_reach_timeout", int'(k >= 700), 0);
    lv("dead_busy", int'(busy[0]), 1);
    n = 0;
    while (!hbInA[0] && n < 400) begin
      if (hbEn[0] || hbInB[0]) n = 1000;
      @(negedge clock);
      n++;
    end
    lv("dead_len", n, 200);
    lv("rev_run_A", int'(hbInA[0]), 1);
    lv("rev_run_B", int'(hbInB[0]), 0);
    lv("rev_run_busy", int'(busy[0]), 0);
    drain("reverse");

    // Test 4: collision mid-pulse at 80
    dutyPct[6:0] = 7'd80;
    pushRamp(50, 80, 10);
    drain("ramp80");
    k = 0;
    while (!hbEn[0] && k < 200) begin
      @(negedge clock);
      k++;
    end
    lv("pulse_start_timeout", int'(k >= 200), 0);
    expQ.push_back(21);
    waitNeg(19);
    collision = 1'b1;
    @(negedge clock);
    collision = 1'b0;
    lv("coll_stopped", int'(stopped), 1);
    @(negedge clock);
    lv("coll_hbEn_off", int'(hbEn[0]), 0);
    collision = 1'b1;
    @(negedge clock);
    resume = 1'b1;
    @(negedge clock);
    resume = 1'b0;
    @(negedge clock);
    lv("resume_ignored", int'(stopped), 1);
    collision = 1'b0;
    waitNeg(2);
    lv("stop_still", int'(stopped), 1);
    lv("stop_ch0_A", int'(hbInA[0]), 0);
    lv("stop_ch0_B", int'(hbInB[0]), 0);
    lv("stop_ch1_A", int'(hbInA[1]), 0);
    lv("stop_ch1_B", int'(hbInB[1]), 0);
    hi = 0;
    for (int c = 0; c < 250; c++) begin
      @(negedge clock);
      if (hbEn[0]) hi++;
    end
    lv("stop_no_pulse", hi, 0);
    lv("stop_trunc_seen", expQ.size(), 0);
    pushRamp(10, 80, 10);
    expQ.push_back(80);
    resume = 1'b1;
    @(negedge clock);
    resume = 1'b0;
    @(negedge clock);
    lv("resume_clear", int'(stopped), 0);
    @(negedge clock);
    lv("resume_ch0_A", int'(hbInA[0]), 1);
    lv("resume_ch0_B", int'(hbInB[0]), 0);
    lv("resume_ch1_A", int'(hbInA[1]), 1);
    drain("resume_ramp");
    dutyPct[6:0] = 7'd0;
    pushRamp(70, 10, -10);
    drain("ramp0_b");

    // Test 6: collision and resume together
    collision = 1'b1;
    resume = 1'b1;
    @(negedge clock);
    collision = 1'b0;
    resume = 1'b0;
    @(negedge clock);
    lv("simul_stopped", int'(stopped), 1);
    resume = 1'b1;
    @(negedge clock);
    resume = 1'b0;
    @(negedge clock);
    lv("simul_cleared", int'(stopped), 0);

    // Test 5: async reset in DEAD
    dirRev[0] = 1'b0;
    k = 0;
    while (!(busy[0] && !hbInA[0] && !hbInB[0]) && k < 500) begin
      @(negedge clock);
      k++;
    end
    lv("dead2_timeout", int'(k >= 500), 0);
    lv("dead2_ch1_A", int'(hbInA[1]), 1);
    #2;
    resetN = 1'b0;
    #1;
    lv("arst_hbEn", int'(hbEn), 0);
    lv("arst_inA", int'(hbInA), 0);
    lv("arst_inB", int'(hbInB), 0);
    lv("arst_stopped", int'(stopped), 0);
    lv("arst_busy", int'(busy), 0);
    @(negedge clock);
    resetN = 1'b1;
    waitNeg(3);
    lv("post_ch0_B", int'(hbInB[0]), 1);
    lv("post_ch0_A", int'(hbInA[0]), 0);
    lv("post_busy", int'(busy), 0);

    waitNeg(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pwm_motor_driver
`default_nettype wire
